// File: rtl/xge_rx_pkt_sink_pkg.sv
// Shared types and helpers for the xge_mac receive packet sink.
package xge_rx_sink_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HUNT,
    BODY
  } state_e;

  localparam logic [2:0] MOD_FULL = 3'd0;

  // Byte count of an eop word; a mod of zero means all eight bytes are valid.
  function automatic logic [3:0] eop_bytes(input logic [2:0] mod);
    return (mod == MOD_FULL) ? 4'd8 : {1'b0, mod};
  endfunction

endpackage

// File: rtl/xge_rx_pkt_sink_sat_counter.sv
// Statistics counter that sticks at all-ones; clear wins over increment.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc_en,
  input  logic [W-1:0] inc_val,
  output logic [W-1:0] q
);

  logic [W:0] sum;

  always_comb begin
    sum = {1'b0, q} + {1'b0, inc_val};
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (inc_en) begin
      q <= sum[W] ? '1 : sum[W-1:0];
    end
  end

endmodule

// File: rtl/xge_rx_pkt_sink.sv
// Drains packets from the xge_mac receive FIFO, checks sop/eop framing,
// forwards accepted words one register stage later and keeps statistics.
module xge_rx_pkt_sink
  import xge_rx_sink_pkg::*;
#(
  parameter int unsigned CW      = 32,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic          clk_156m25,
  input  logic          reset_156m25,
  input  logic          pkt_rx_avail,
  output logic          pkt_rx_ren,
  input  logic [63:0]   pkt_rx_data,
  input  logic          pkt_rx_val,
  input  logic          pkt_rx_sop,
  input  logic          pkt_rx_eop,
  input  logic [2:0]    pkt_rx_mod,
  input  logic          pkt_rx_err,
  output logic [63:0]   out_data,
  output logic          out_val,
  output logic          out_sop,
  output logic          out_eop,
  output logic [2:0]    out_mod,
  output logic          out_err,
  output logic          pkt_done,
  output logic [15:0]   pkt_len,
  input  logic          stat_clr,
  output logic [CW-1:0] pkt_cnt,
  output logic [CW-1:0] byte_cnt,
  output logic [CW-1:0] err_cnt,
  output logic [CW-1:0] frame_err_cnt,
  output logic [CW-1:0] timeout_cnt
);

  localparam logic [12:0] WC_MAX = '1;

  state_e        state_q;
  logic          ren_q;
  logic [12:0]   wc_q;
  logic [16:0]   tmo_q;
  logic [63:0]   out_data_q;
  logic          out_val_q, out_sop_q, out_eop_q, out_err_q, pkt_done_q;
  logic [2:0]    out_mod_q;
  logic [15:0]   pkt_len_q;

  logic          busy, hunt_sop, accept, frame_err, eop_hit, tmo_hit;
  logic [12:0]   words;
  logic [15:0]   len_d;
  logic [16:0]   tmo_next;
  logic [CW+15:0] byte_wide;
  logic [CW-1:0] byte_inc;

  always_comb begin
    busy      = (state_q != IDLE);
    hunt_sop  = (state_q == HUNT) && pkt_rx_val && pkt_rx_sop;
    accept    = hunt_sop || ((state_q == BODY) && pkt_rx_val);
    frame_err = pkt_rx_val && (((state_q == HUNT) && !pkt_rx_sop) ||
                               ((state_q == BODY) && pkt_rx_sop));
    eop_hit   = accept && pkt_rx_eop;
    // A sop word (first or mid-packet) always restarts the length at one word.
    if (pkt_rx_sop)          words = 13'd1;
    else if (wc_q == WC_MAX) words = WC_MAX;
    else                     words = wc_q + 13'd1;
    len_d     = (({3'b000, words} - 16'd1) << 3) + {12'd0, eop_bytes(pkt_rx_mod)};
    byte_wide = {{CW{1'b0}}, len_d};
    byte_inc  = ((byte_wide >> CW) != '0) ? '1 : byte_wide[CW-1:0];
    tmo_next  = tmo_q + 17'd1;
    tmo_hit   = busy && !eop_hit && (tmo_next == 17'(TIMEOUT));
  end

  always_ff @(posedge clk_156m25) begin
    if (reset_156m25) begin
      state_q    <= IDLE;
      ren_q      <= 1'b0;
      wc_q       <= '0;
      tmo_q      <= '0;
      out_data_q <= '0;
      out_val_q  <= 1'b0;
      out_sop_q  <= 1'b0;
      out_eop_q  <= 1'b0;
      out_mod_q  <= '0;
      out_err_q  <= 1'b0;
      pkt_done_q <= 1'b0;
      pkt_len_q  <= '0;
    end else begin
      out_val_q  <= accept;
      out_data_q <= accept ? pkt_rx_data : '0;
      out_sop_q  <= accept && pkt_rx_sop;
      out_eop_q  <= eop_hit;
      out_mod_q  <= accept ? pkt_rx_mod : '0;
      out_err_q  <= accept && pkt_rx_err;
      pkt_done_q <= eop_hit;
      pkt_len_q  <= eop_hit ? len_d : '0;
      case (state_q)
        IDLE: begin
          if (pkt_rx_avail) begin
            ren_q   <= 1'b1;
            wc_q    <= '0;
            tmo_q   <= '0;
            state_q <= HUNT;
          end
        end
        HUNT, BODY: begin
          if (accept) wc_q <= words;
          if (eop_hit || tmo_hit) begin
            ren_q   <= 1'b0;
            state_q <= IDLE;
          end else begin
            tmo_q <= tmo_next;
            if (hunt_sop) state_q <= BODY;
          end
        end
        default: begin
          ren_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign pkt_rx_ren = ren_q;
  assign out_data   = out_data_q;
  assign out_val    = out_val_q;
  assign out_sop    = out_sop_q;
  assign out_eop    = out_eop_q;
  assign out_mod    = out_mod_q;
  assign out_err    = out_err_q;
  assign pkt_done   = pkt_done_q;
  assign pkt_len    = pkt_len_q;

  sat_counter #(.W(CW)) u_pkt_cnt (
    .clk(clk_156m25), .rst(reset_156m25), .clr(stat_clr),
    .inc_en(eop_hit), .inc_val(CW'(1)), .q(pkt_cnt)
  );

  sat_counter #(.W(CW)) u_byte_cnt (
    .clk(clk_156m25), .rst(reset_156m25), .clr(stat_clr),
    .inc_en(eop_hit), .inc_val(byte_inc), .q(byte_cnt)
  );

  sat_counter #(.W(CW)) u_err_cnt (
    .clk(clk_156m25), .rst(reset_156m25), .clr(stat_clr),
    .inc_en(eop_hit && pkt_rx_err), .inc_val(CW'(1)), .q(err_cnt)
  );

  sat_counter #(.W(CW)) u_frame_err_cnt (
    .clk(clk_156m25), .rst(reset_156m25), .clr(stat_clr),
    .inc_en(frame_err), .inc_val(CW'(1)), .q(frame_err_cnt)
  );

  sat_counter #(.W(CW)) u_timeout_cnt (
    .clk(clk_156m25), .rst(reset_156m25), .clr(stat_clr),
    .inc_en(tmo_hit), .inc_val(CW'(1)), .q(timeout_cnt)
  );

endmodule

// File: doc/xge_rx_pkt_sink.md
# xge_rx_pkt_sink

Receive-side packet sink for the `xge_mac` core. It sits directly downstream of the MAC's packet receive interface. It detects `pkt_rx_avail`, drives `pkt_rx_ren` to drain one packet at a time, and checks sop/eop framing. It forwards accepted words on a registered output stream and keeps saturating packet, byte, error and timeout statistics for the UVM environment and for on-chip status readout.

## Interface
- `CW`, 32: width of each statistics counter.
- `TIMEOUT`, 4096: maximum cycles `pkt_rx_ren` may stay high without an eop being seen; range 2..2^16.
- `clk_156m25`  in  1  core clock, shared with the MAC packet interface.
- `reset_156m25`  in  1  reset, **synchronous, active-high**. One clock domain only.
- `pkt_rx_avail`  in  1  MAC has at least one complete packet queued.
- `pkt_rx_ren`  out  1  read enable to MAC.
- `pkt_rx_data`  in  64  receive word; byte 0 is in bits 63:56.
- `pkt_rx_val`  in  1  word valid.
- `pkt_rx_sop`  in  1  first word of packet.
- `pkt_rx_eop`  in  1  last word of packet.
- `pkt_rx_mod`  in  3  valid bytes in the eop word; 0 means 8.
- `pkt_rx_err`  in  1  MAC error flag, qualified by eop.
- `out_data`  out  64  forwarded word.
- `out_val`, `out_sop`, `out_eop`  out  1 each  forwarded qualifiers.
- `out_mod`  out  3  forwarded mod.
- `out_err`  out  1  forwarded err.
- `pkt_done`  out  1  one-cycle pulse with `out_eop`.
- `pkt_len`  out  16  byte length of the completed packet; valid while `pkt_done` is high.
- `stat_clr`  in  1  synchronous clear of all counters.
- `pkt_cnt`, `byte_cnt`, `err_cnt`, `frame_err_cnt`, `timeout_cnt`  out  CW each  statistics.

## Operation
- Reset value of every output is 0. The FSM resets to `IDLE`.
- FSM states:
  - `IDLE`: if `pkt_rx_avail` is high, set `pkt_rx_ren` to 1, clear the word and timeout counters, and go to `HUNT`.
  - `HUNT`: wait for the first word of the packet.
    - `val & sop`: accept the word, set the word count to 1, go to `BODY`.
    - `val & !sop`: count one frame error and drop the word; it is not forwarded.
  - `BODY`: each `val` word is accepted and increments the word count.
    - `val & sop` in `BODY`: count one frame error, forward the word, restart the word count at 1.
- eop is handled only in `HUNT` (on a word with sop) or `BODY`. On `val & eop`:
  - clear `pkt_rx_ren` at the same edge;
  - `pkt_len` = (words−1)·8 + (mod==0 ? 8 : mod);
  - `pkt_cnt` += 1; `byte_cnt` += `pkt_len`;
  - `err_cnt` += 1 if `pkt_rx_err`;
  - go to `IDLE`.
- sop and eop on the same word form a single-word packet, length 1..8.
- Timeout: in `HUNT` or `BODY`, the timeout counter increments every cycle without `val & eop`. When it reaches `TIMEOUT`:
  - clear `pkt_rx_ren`, `timeout_cnt` += 1, go to `IDLE`;
  - no `pkt_done` pulse;
  - if a packet was open, the last forwarded word carries no eop. The downstream consumer discards on the next `out_sop`.
- Counters saturate at 2^CW−1. `byte_cnt` saturates on overflow of the addition and never wraps.
- The word counter saturates at 2^13−1.
- `stat_clr` beats any same-cycle increment: the counter reads 0 afterwards.
- `reset_156m25` during a packet aborts it immediately. `pkt_rx_ren` is 0 on the next cycle.

## Timing
- `pkt_rx_ren` rises on the edge after `pkt_rx_avail` is sampled high in `IDLE`.
- The MAC returns the first `val` at least one cycle later.
- The output stream is one register stage:
  - `out_*` at cycle n+1 mirrors the accepted input at cycle n;
  - `out_val` is 0 for dropped words.
- `pkt_done` and `pkt_len` appear in the same cycle as `out_eop`.
- Counters update on the same edge that raises `pkt_done`.
- After eop, `IDLE` re-samples `pkt_rx_avail` on the next cycle. Minimum gap between packets is 2 cycles with `pkt_rx_ren` low in between.
- `out_*` has no backpressure; the consumer must accept one word per cycle.

## Structure
- Package `xge_rx_sink_pkg` holds:
  - state enum `{IDLE, HUNT, BODY}`;
  - `MOD_FULL` = 3'd0;
  - function `eop_bytes(mod)` returning 1..8.
- One sub-module `sat_counter` (parameter `W`; inputs `clr`, `inc_en`, `inc_val[W-1:0]`; output `q`). It is instantiated five times.

## Test plan
- 64-byte packet (8 words, mod=0) with avail high: `pkt_rx_ren` rises next cycle and drops on the eop edge; `pkt_len`=64, `pkt_cnt`=1, `byte_cnt`=64.
- 61-byte packet, mod=5 on word 8: `pkt_len`=61. A following 1-byte single-word packet (sop=eop=1, mod=1) gives `pkt_len`=1, `byte_cnt`=62.
- Packet with `pkt_rx_err`=1 on eop: `out_err`=1, `err_cnt`=1, `pkt_cnt`=1.
- First word `val & !sop`, then a normal 2-word packet: `frame_err_cnt`=1, the dropped word has `out_val`=0, `pkt_len`=16.
- `TIMEOUT`=16, avail high, MAC never asserts val: `pkt_rx_ren` high for 16 cycles then low, `timeout_cnt`=1, no `pkt_done`.
- `CW`=4, 16 packets sent: `pkt_cnt` holds at 15. `stat_clr` asserted with a same-cycle eop: all counters read 0.
